// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: expands reset/IR/DR/idle commands into TMS/TDI walks and tracks the TAP state.
// Optional feature macro: JTAG_SEQ_TDO_CAPTURE_EN (capture TDO into rsp_data; otherwise rsp_data is 0).
module jtag_scan_sequencer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic               tck,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SELDR, TAP_CAPDR, TAP_SHDR, TAP_EX1DR, TAP_PADR, TAP_EX2DR,
    TAP_UPDR, TAP_SELIR, TAP_CAPIR, TAP_SHIR, TAP_EX1IR, TAP_PAIR, TAP_EX2IR, TAP_UPIR
  } tap_state_e;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HEAD, S_SHIFT, S_TAIL, S_RSP} seq_state_e;

  // IEEE 1149.1 TAP transition graph, used to shadow the target controller
  function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
    case (s)
      TAP_TLR:   return m ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   return m ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: return m ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: return m ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  return m ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: return m ? TAP_UPDR  : TAP_PADR;
      TAP_PADR:  return m ? TAP_EX2DR : TAP_PADR;
      TAP_EX2DR: return m ? TAP_UPDR  : TAP_SHDR;
      TAP_UPDR:  return m ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: return m ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: return m ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  return m ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: return m ? TAP_UPIR  : TAP_PAIR;
      TAP_PAIR:  return m ? TAP_EX2IR : TAP_PAIR;
      TAP_EX2IR: return m ? TAP_UPIR  : TAP_SHIR;
      TAP_UPIR:  return m ? TAP_SELDR : TAP_RTI;
      default:   return TAP_TLR;
    endcase
  endfunction

  seq_state_e         st_q, st_d;
  tap_state_e         shadow_q, shadow_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [1:0]         op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic               tms_q, tms_d, tdi_q, tdi_d;
  logic               busy_q, busy_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic               accept_c, cap_en_c, head_tms_c;
  logic [IDX_W-1:0]   cap_idx_c;
  logic [LEN_W-1:0]   len_clamp_c, head_len_c;

  assign accept_c = cmd_valid && ready_q;

  always_comb begin
    len_clamp_c = cmd_len;
    if (cmd_len == '0) begin
      len_clamp_c = LEN_W'(1);
    end else if (cmd_len > LEN_W'(MAX_LEN)) begin
      len_clamp_c = LEN_W'(MAX_LEN);
    end
  end

  // Opening TMS walk from RTI; an idle command is a head of len_q zeros
  always_comb begin
    head_len_c = len_q;
    head_tms_c = 1'b0;
    case (op_q)
      OP_RESET: begin head_len_c = LEN_W'(5); head_tms_c = 1'b1; end
      OP_IR:    begin head_len_c = LEN_W'(4); head_tms_c = (cnt_q < LEN_W'(2)); end
      OP_DR:    begin head_len_c = LEN_W'(3); head_tms_c = (cnt_q == '0); end
      default:  ;
    endcase
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    tms_d       = tms_q;
    tdi_d       = 1'b0;
    busy_d      = busy_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    cap_en_c    = 1'b0;
    cap_idx_c   = '0;
    case (st_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (accept_c) begin
          op_d    = cmd_op;
          len_d   = len_clamp_c;
          data_d  = cmd_data;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
          st_d    = (shadow_q == TAP_TLR && cmd_op != OP_RESET) ? S_PRE : S_HEAD;
        end
      end
      S_PRE: begin
        tms_d = 1'b0;
        st_d  = S_HEAD;
      end
      S_HEAD: begin
        tms_d = head_tms_c;
        if (cnt_q == head_len_c - LEN_W'(1)) begin
          cnt_d = '0;
          st_d  = (op_q == OP_IR || op_q == OP_DR) ? S_SHIFT : S_RSP;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_SHIFT: begin
        tdi_d     = data_q[IDX_W'(cnt_q)];
        // TDO for shift bit i arrives at the edge that launches bit i+1
        cap_en_c  = (cnt_q != '0);
        cap_idx_c = IDX_W'(cnt_q - LEN_W'(1));
        if (cnt_q == len_q - LEN_W'(1)) begin
          tms_d = 1'b1;
          cnt_d = '0;
          st_d  = S_TAIL;
        end else begin
          tms_d = 1'b0;
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_TAIL: begin
        if (cnt_q == '0) begin
          tms_d     = 1'b1;
          cnt_d     = LEN_W'(1);
          cap_en_c  = 1'b1;
          cap_idx_c = IDX_W'(len_q - LEN_W'(1));
        end else begin
          tms_d = 1'b0;
          cnt_d = '0;
          st_d  = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        st_d        = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    shadow_d = tap_next(shadow_q, tms_d);
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      st_q        <= S_IDLE;
      shadow_q    <= TAP_TLR;
      cnt_q       <= '0;
      len_q       <= '0;
      op_q        <= OP_RESET;
      data_q      <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      op_q        <= op_d;
      data_q      <= data_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;

`ifdef JTAG_SEQ_TDO_CAPTURE_EN
  logic [MAX_LEN-1:0] cap_q, cap_d, rsp_data_q, rsp_data_d;

  always_comb begin
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    if (accept_c) begin
      cap_d = '0;
    end else if (cap_en_c) begin
      cap_d[cap_idx_c] = tdo;
    end
    if (st_q == S_RSP) begin
      rsp_data_d = cap_q;
    end
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      cap_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_data = rsp_data_q;
`else
  logic unused_capture;
  assign unused_capture = tdo ^ cap_en_c ^ (^cap_idx_c);
  assign rsp_data       = '0;
`endif

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: table of commands plus scoreboard of per-cycle TMS/TDI and responses.
module tb_jtag_scan_sequencer;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned NVEC    = 11;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic               tck = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               tms, tdi, tdo, busy, rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;

  always #5 tck = ~tck;

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck(tck), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  // One-bit scan chain: tdo is tdi delayed by one cycle
  always @(posedge tck or posedge reset) begin
    if (reset) tdo <= 1'b0;
    else       tdo <= tdi;
  end

  typedef struct {
    logic [1:0]         op;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] data;
    bit                 hold;
    int                 cycles;
    logic [MAX_LEN-1:0] rsp;
  } vec_t;

  vec_t               vec [NVEC];
  logic [1:0]         exp_q [$];
  logic [MAX_LEN-1:0] rsp_q [$];
  int                 total = 0;
  int                 bad = 0;
  bit                 tlr = 1'b1;
  logic [MAX_LEN-1:0] last_rsp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input logic [LEN_W-1:0] len);
    if (len == 0) return 1;
    if (int'(len) > int'(MAX_LEN)) return int'(MAX_LEN);
    return int'(len);
  endfunction

  // Expected {tms,tdi} per sequence cycle
  task automatic push_seq(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data, input bit from_tlr);
    if (from_tlr && op != 2'b00) exp_q.push_back(2'b00);
    case (op)
      2'b00: repeat (5) exp_q.push_back(2'b10);
      2'b11: repeat (len) exp_q.push_back(2'b00);
      default: begin
        exp_q.push_back(2'b10);
        if (op == 2'b01) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), data[i]});
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
      end
    endcase
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge tck); #1;
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL wait_ready: cmd_ready still %b after %0d cycles", cmd_ready, n);
    end
  endtask

  task automatic run_cmd(input vec_t v, input bit hold, input vec_t nv);
    logic [1:0]         e;
    logic [MAX_LEN-1:0] er;
    logic               idle_tms;
    cmd_op = v.op; cmd_len = v.len; cmd_data = v.data; cmd_valid = 1'b1;
    wait_ready();
    push_seq(v.op, clamp_len(v.len), v.data, tlr);
    rsp_q.push_back(CAP_EN ? v.rsp : '0);
    idle_tms = tlr;
    @(posedge tck); #1;
    if (hold) begin
      cmd_op = nv.op; cmd_len = nv.len; cmd_data = nv.data;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("accept", {tms, tdi, busy, cmd_ready, rsp_valid}, {idle_tms, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= v.cycles; k++) begin
      @(posedge tck); #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL seq_len: cycle %0d got tms=%b but no further bit expected", k, tms);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("tms_tdi op%0d c%0d", v.op, k), {tms, tdi}, e);
      end
      chk($sformatf("busy_ctl op%0d c%0d", v.op, k), {busy, cmd_ready, rsp_valid, rsp_data},
          {1'b1, 1'b0, 1'b0, last_rsp});
    end
    @(posedge tck); #1;
    chk($sformatf("rsp_ctl op%0d", v.op), {busy, cmd_ready, rsp_valid, tdi}, 4'b1110);
    er = rsp_q.pop_front();
    chk($sformatf("rsp_data op%0d len%0d", v.op, v.len), rsp_data, er);
    last_rsp = er;
    exp_q.delete();
    tlr = (v.op == 2'b00);
  endtask

  initial begin
    int pulses;
    int ones;
    vec_t post;
    //            op     len     data            hold  cyc  rsp (with capture)
    vec[0]  = '{2'b00, 6'd0,  32'h0000_0000, 1'b0,  5, 32'h0000_0000};
    vec[1]  = '{2'b01, 6'd4,  32'h0000_0005, 1'b0, 11, 32'h0000_000A};
    vec[2]  = '{2'b10, 6'd8,  32'h0000_00A5, 1'b0, 13, 32'h0000_004A};
    vec[3]  = '{2'b10, 6'd0,  32'hFFFF_FFFF, 1'b0,  6, 32'h0000_0000};
    vec[4]  = '{2'b10, 6'd40, 32'h8000_0001, 1'b0, 37, 32'h0000_0002};
    vec[5]  = '{2'b01, 6'd32, 32'hDEAD_BEEF, 1'b0, 38, 32'hBD5B_7DDE};
    vec[6]  = '{2'b11, 6'd3,  32'hFFFF_FFFF, 1'b1,  3, 32'h0000_0000};
    vec[7]  = '{2'b01, 6'd5,  32'h0000_0013, 1'b0, 11, 32'h0000_0006};
    vec[8]  = '{2'b00, 6'd7,  32'h1234_5678, 1'b0,  5, 32'h0000_0000};
    vec[9]  = '{2'b11, 6'd2,  32'h0000_0000, 1'b0,  3, 32'h0000_0000};
    vec[10] = '{2'b10, 6'd63, 32'h1234_5678, 1'b0, 37, 32'h2468_ACF0};

    #12;
    chk("reset_state", {tms, tdi, cmd_ready, busy, rsp_valid, rsp_data}, {5'b10100, 32'h0});
    reset = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      run_cmd(vec[i], vec[i].hold, vec[(i + 1 < int'(NVEC)) ? i + 1 : i]);
    end

    // Abort a DR scan mid-shift with reset
    cmd_op = 2'b10; cmd_len = 6'd16; cmd_data = 32'h0000_FFFF; cmd_valid = 1'b1;
    wait_ready();
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge tck);
    #1;
    chk("pre_abort", {tms, tdi, busy}, 3'b011);
    #1 reset = 1'b1;
    #1;
    chk("abort_async", {tms, tdi, busy, cmd_ready, rsp_valid, rsp_data}, {5'b10010, 32'h0});
    #3 reset = 1'b0;
    pulses = 0;
    ones = 0;
    repeat (40) begin
      @(posedge tck); #1;
      if (rsp_valid) pulses++;
      if (tms) ones++;
    end
    chk("abort_no_rsp", pulses, 0);
    chk("abort_tms_high", ones, 40);
    tlr = 1'b1;
    last_rsp = '0;
    post = '{2'b10, 6'd4, 32'h0000_0009, 1'b0, 10, 32'h0000_0002};
    run_cmd(post, 1'b0, post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
